// File: rtl/rom_dl_pkg.sv
// Shared types and address swizzles for the ROM download scheduler.
// The swizzles map a byte address to an SDRAM word address plus byte strobes.
package rom_dl_pkg;

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, LOCAL} state_e;
    typedef enum logic [1:0] {RG_P1, RG_P2, RG_LOCAL} region_e;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } dl_entry_t;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
    } sd_cmd_t;

    // Main/CSD: the upper 64K bank has bit 14 rotated down to the byte select.
    function automatic sd_cmd_t p1_map(input logic [24:0] addr);
        sd_cmd_t     c;
        logic [24:0] r;
        r    = addr[16] ? {addr[24:16], addr[15], addr[13:0], addr[14]} : addr;
        c.a  = r[23:1];
        c.ds = {r[0], ~r[0]};
        return c;
    endfunction

    // Sprites: s is the offset from the sprite region base.
    function automatic sd_cmd_t p2_map(input logic [24:0] s);
        sd_cmd_t c;
        c.a  = {s[23:17], s[14:0], s[16]};
        c.ds = {s[15], ~s[15]};
        return c;
    endfunction

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO for captured download strobes.
// A push while full is accepted only when a pop happens in the same cycle.
module dl_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push, w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/rom_dl_scheduler.sv
// Routes ioctl download bytes to SDRAM port1/port2 or on-chip RAM, one
// toggle req/ack transfer outstanding at a time, and flags when the ROM is loaded.
module rom_dl_scheduler
    import rom_dl_pkg::*;
#(
    parameter logic [24:0] SP_BASE    = 25'h18000,
    parameter logic [24:0] BG_BASE    = 25'h38000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ioctl_downl,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    output logic        o_port1_req,
    input  logic        i_port1_ack,
    output logic [22:0] o_port1_a,
    output logic [1:0]  o_port1_ds,
    output logic [15:0] o_port1_d,
    output logic        o_port2_req,
    input  logic        i_port2_ack,
    output logic [22:0] o_port2_a,
    output logic [1:0]  o_port2_ds,
    output logic [15:0] o_port2_d,
    output logic        o_port_we,
    output logic [18:0] o_dl_addr,
    output logic [7:0]  o_dl_data,
    output logic        o_dl_wr,
    output logic        o_overflow,
    output logic        o_busy,
    output logic        o_rom_loaded
);
    state_e    r_state, w_state_nxt;
    region_e   w_region;
    dl_entry_t w_head, w_cap;
    sd_cmd_t   w_p1_cmd, w_p2_cmd;
    logic      w_full, w_empty, w_pop, w_wr_rise, w_downl_rise, w_busy;
    logic      r_wr_d, r_downl_d, r_overflow, r_started, r_rom_loaded;
    logic      r_p1_req, r_p2_req, r_dl_wr;
    logic [22:0] r_p1_a, r_p2_a;
    logic [1:0]  r_p1_ds, r_p2_ds;
    logic [15:0] r_p1_d, r_p2_d;
    logic [18:0] r_dl_addr;
    logic [7:0]  r_dl_data;

    assign w_wr_rise    = i_ioctl_wr & ~r_wr_d & i_ioctl_downl;
    assign w_downl_rise = i_ioctl_downl & ~r_downl_d;
    assign w_cap        = '{addr: i_ioctl_addr, data: i_ioctl_dout};

    dl_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(dl_entry_t))) u_fifo (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_push  (w_wr_rise),
        .i_data  (w_cap),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_region = (w_head.addr < SP_BASE) ? RG_P1 :
                      (w_head.addr < BG_BASE) ? RG_P2 : RG_LOCAL;
    assign w_p1_cmd = p1_map(w_head.addr);
    assign w_p2_cmd = p2_map(w_head.addr - SP_BASE);
    assign w_busy   = ~w_empty | (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) begin
                w_pop = 1'b1;
                case (w_region)
                    RG_P1:   w_state_nxt = WAIT1;
                    RG_P2:   w_state_nxt = WAIT2;
                    default: w_state_nxt = LOCAL;
                endcase
            end
            WAIT1:   if (i_port1_ack == r_p1_req) w_state_nxt = IDLE;
            WAIT2:   if (i_port2_ack == r_p2_req) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Requests resync to the ack level so a reset never looks like a new request.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_p1_req  <= i_port1_ack;
            r_p2_req  <= i_port2_ack;
            r_p1_a    <= '0;
            r_p1_ds   <= '0;
            r_p1_d    <= '0;
            r_p2_a    <= '0;
            r_p2_ds   <= '0;
            r_p2_d    <= '0;
            r_dl_wr   <= 1'b0;
            r_dl_addr <= '0;
            r_dl_data <= '0;
        end else begin
            r_dl_wr <= w_pop && (w_region == RG_LOCAL);
            if (w_pop) begin
                case (w_region)
                    RG_P1: begin
                        r_p1_req <= ~r_p1_req;
                        r_p1_a   <= w_p1_cmd.a;
                        r_p1_ds  <= w_p1_cmd.ds;
                        r_p1_d   <= {w_head.data, w_head.data};
                    end
                    RG_P2: begin
                        r_p2_req <= ~r_p2_req;
                        r_p2_a   <= w_p2_cmd.a;
                        r_p2_ds  <= w_p2_cmd.ds;
                        r_p2_d   <= {w_head.data, w_head.data};
                    end
                    default: begin
                        r_dl_addr <= 19'(w_head.addr - BG_BASE);
                        r_dl_data <= w_head.data;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_wr_d       <= 1'b0;
            r_downl_d    <= 1'b0;
            r_overflow   <= 1'b0;
            r_started    <= 1'b0;
            r_rom_loaded <= 1'b0;
        end else begin
            r_wr_d    <= i_ioctl_wr;
            r_downl_d <= i_ioctl_downl;
            if (w_downl_rise)                        r_overflow <= 1'b0;
            else if (w_wr_rise && w_full && !w_pop)  r_overflow <= 1'b1;
            if (i_ioctl_downl)                       r_started <= 1'b1;
            if (r_started && !i_ioctl_downl && !w_busy) r_rom_loaded <= 1'b1;
        end
    end

    assign o_port1_req  = r_p1_req;
    assign o_port1_a    = r_p1_a;
    assign o_port1_ds   = r_p1_ds;
    assign o_port1_d    = r_p1_d;
    assign o_port2_req  = r_p2_req;
    assign o_port2_a    = r_p2_a;
    assign o_port2_ds   = r_p2_ds;
    assign o_port2_d    = r_p2_d;
    assign o_port_we    = i_ioctl_downl | w_busy;
    assign o_dl_addr    = r_dl_addr;
    assign o_dl_data    = r_dl_data;
    assign o_dl_wr      = r_dl_wr;
    assign o_overflow   = r_overflow;
    assign o_busy       = w_busy;
    assign o_rom_loaded = r_rom_loaded;

endmodule

// File: tb/tb_rom_dl_scheduler.sv
// Scoreboard bench for rom_dl_scheduler: directed cases plus randomized bytes
// checked against an arithmetic reference model of the region/swizzle rules.
module tb_rom_dl_scheduler;
    localparam int SP = 'h18000;
    localparam int BG = 'h38000;

    logic clk = 0, rst = 1, downl = 0, wr = 0;
    logic [24:0] addr = '0;
    logic [7:0]  dout = '0;
    logic ack1 = 0, ack2 = 0;
    logic p1_req, p2_req, port_we, dl_wr, ovf, busy, loaded;
    logic [22:0] p1_a, p2_a;
    logic [1:0]  p1_ds, p2_ds;
    logic [15:0] p1_d, p2_d;
    logic [18:0] dl_addr;
    logic [7:0]  dl_data;

    rom_dl_scheduler dut (
        .i_clk_sys(clk), .i_reset(rst), .i_ioctl_downl(downl), .i_ioctl_wr(wr),
        .i_ioctl_addr(addr), .i_ioctl_dout(dout),
        .o_port1_req(p1_req), .i_port1_ack(ack1), .o_port1_a(p1_a), .o_port1_ds(p1_ds), .o_port1_d(p1_d),
        .o_port2_req(p2_req), .i_port2_ack(ack2), .o_port2_a(p2_a), .o_port2_ds(p2_ds), .o_port2_d(p2_d),
        .o_port_we(port_we), .o_dl_addr(dl_addr), .o_dl_data(dl_data), .o_dl_wr(dl_wr),
        .o_overflow(ovf), .o_busy(busy), .o_rom_loaded(loaded)
    );

    // kind: 1 = port1, 2 = port2, 3 = local write
    typedef struct {
        int          kind;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
        bit          chk_lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;
    bit   hold1 = 0, hold2 = 0, ovr1 = 0;
    int   lat1 = 3, lat2 = 2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [22:0] a, input logic [1:0] ds,
                                input logic [15:0] d, input bit lat);
        exp_t e;
        e.kind = k; e.a = a; e.ds = ds; e.d = d; e.chk_lat = lat; e.t0 = 0;
        return e;
    endfunction

    // Reference model: region by address range, swizzles as bit arithmetic.
    function automatic exp_t model(input int a, input logic [7:0] d);
        int r, s;
        if (a < SP) begin
            r = a;
            if (((a >> 16) & 1) == 1)
                r = ((a >> 16) << 16) | (((a >> 15) & 1) << 15) | ((a & 'h3FFF) << 1) | ((a >> 14) & 1);
            return mk(1, 23'((r >> 1) & 'h7FFFFF), (r & 1) ? 2'b10 : 2'b01, {d, d}, 0);
        end else if (a < BG) begin
            s = a - SP;
            r = (((s >> 17) & 'h7F) << 16) | ((s & 'h7FFF) << 1) | ((s >> 16) & 1);
            return mk(2, 23'(r), ((s >> 15) & 1) ? 2'b10 : 2'b01, {d, d}, 0);
        end
        return mk(3, 23'((a - BG) & 'h7FFFF), 2'b00, {8'h00, d}, 0);
    endfunction

    task automatic issue(input int a, input logic [7:0] d, input exp_t e, input bit expect_it, input int width);
        exp_t x = e;
        @(negedge clk);
        addr = 25'(a); dout = d; wr = 1;
        x.t0 = cyc;
        if (expect_it) sb.push_back(x);
        repeat (width) @(negedge clk);
        wr = 0;
    endtask

    task automatic got(input int k, input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_output_kind", 64'(k), 64'(0));
            return;
        end
        e = sb.pop_front();
        chk("out_kind", 64'(k), 64'(e.kind));
        chk("out_addr", 64'(a), 64'(e.a));
        chk("out_ds", 64'(ds), 64'(e.ds));
        chk("out_data", 64'(d), 64'(e.d));
        if (e.chk_lat) chk("latency", 64'(cyc - e.t0), 64'(2));
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 64'(t < 2000), 64'(1));
    endtask

    // Ack responder: echoes req after lat cycles unless held.
    initial begin
        int c1 = 0, c2 = 0;
        forever begin
            @(negedge clk);
            if (ovr1) ack1 = 1;
            else if (!rst && !hold1 && p1_req != ack1) begin
                c1++;
                if (c1 >= lat1) begin ack1 = p1_req; c1 = 0; end
            end else c1 = 0;
            if (!rst && !hold2 && p2_req != ack2) begin
                c2++;
                if (c2 >= lat2) begin ack2 = p2_req; c2 = 0; end
            end else c2 = 0;
        end
    end

    // Monitor: every req toggle or dl_wr pulse consumes one scoreboard entry.
    initial begin
        logic pr1 = 0, pr2 = 0, pend1 = 0, pend2 = 0, last_dl = 0;
        logic [40:0] h1 = '0, h2 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pr1 = p1_req; pr2 = p2_req; pend1 = 0; pend2 = 0; last_dl = 0;
                continue;
            end
            chk("port_we", 64'(port_we), 64'(downl | busy));
            if (p1_req != pr1) begin
                got(1, p1_a, p1_ds, p1_d);
                h1 = {p1_a, p1_ds, p1_d}; pend1 = 1;
            end else if (pend1) begin
                if (p1_req == ack1) pend1 = 0;
                else chk("p1_hold", 64'({p1_a, p1_ds, p1_d}), 64'(h1));
            end
            if (p2_req != pr2) begin
                got(2, p2_a, p2_ds, p2_d);
                h2 = {p2_a, p2_ds, p2_d}; pend2 = 1;
            end else if (pend2) begin
                if (p2_req == ack2) pend2 = 0;
                else chk("p2_hold", 64'({p2_a, p2_ds, p2_d}), 64'(h2));
            end
            if (dl_wr) begin
                chk("dl_wr_one_cycle", 64'(last_dl), 64'(0));
                got(3, 23'(dl_addr), 2'b00, {8'h00, dl_data});
            end
            last_dl = dl_wr;
            pr1 = p1_req; pr2 = p2_req;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, t;
        logic [7:0] d;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst_p1_req", 64'(p1_req), 64'(0));
        chk("rst_p2_req", 64'(p2_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overflow", 64'(ovf), 64'(0));
        chk("rst_rom_loaded", 64'(loaded), 64'(0));
        chk("rst_dl_wr", 64'(dl_wr), 64'(0));
        chk("rst_port_we", 64'(port_we), 64'(0));
        rst = 0;
        @(negedge clk); downl = 1;
        repeat (2) @(negedge clk);

        // Directed region cases with literal expectations.
        lat1 = 3;
        issue('h00005, 8'hA5, mk(1, 23'h2, 2'b10, 16'hA5A5, 1), 1, 1);
        drain();
        chk("t1_busy_after_ack", 64'(busy), 64'(0));
        issue('h14001, 8'h5A, mk(1, 23'h8001, 2'b10, 16'h5A5A, 1), 1, 1);
        drain();
        issue('h28000, 8'h3C, mk(2, 23'h1, 2'b01, 16'h3C3C, 1), 1, 1);
        drain();
        issue('h38010, 8'h77, mk(3, 23'h10, 2'b00, 16'h0077, 1), 1, 1);
        drain();

        // Ack stalled: one transfer in flight plus four queued; the sixth is dropped.
        hold1 = 1;
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, SP - 1));
            d = 8'($urandom);
            issue(a, d, model(a, d), i < 5, 1);
        end
        repeat (3) @(negedge clk);
        chk("t5_overflow_set", 64'(ovf), 64'(1));
        chk("t5_busy_stalled", 64'(busy), 64'(1));
        hold1 = 0;
        drain();
        chk("t5_overflow_sticky", 64'(ovf), 64'(1));
        @(negedge clk); downl = 0;
        @(negedge clk); downl = 1;
        repeat (2) @(negedge clk);
        chk("t5_overflow_cleared", 64'(ovf), 64'(0));

        // Randomized traffic, throttled so the FIFO never overflows.
        for (int i = 0; i < 120; i++) begin
            t = 0;
            while (sb.size() >= 3 && t < 1000) begin @(negedge clk); t++; end
            if (t >= 1000) chk("flow_timeout", 64'(0), 64'(1));
            lat1 = int'($urandom_range(1, 4));
            lat2 = int'($urandom_range(1, 4));
            case ($urandom_range(0, 2))
                0:       a = int'($urandom_range(0, SP - 1));
                1:       a = int'($urandom_range(SP, BG - 1));
                default: a = BG + int'($urandom_range(0, 'h7FFFF));
            endcase
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); downl = 0;
                issue(a, d, model(a, d), 0, 1);
                @(negedge clk); downl = 1;
            end else begin
                issue(a, d, model(a, d), 1, int'($urandom_range(1, 3)));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        chk("rand_busy_idle", 64'(busy), 64'(0));
        chk("rand_no_overflow", 64'(ovf), 64'(0));

        // Reset while waiting on port1 with ack driven high.
        hold1 = 1;
        issue('h00100, 8'h11, model('h00100, 8'h11), 1, 1);
        issue('h00200, 8'h22, model('h00200, 8'h22), 1, 1);
        repeat (2) @(negedge clk);
        rst = 1; ovr1 = 1;
        sb.delete();
        repeat (3) @(negedge clk);
        chk("t6_req_resync", 64'(p1_req), 64'(1));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_overflow", 64'(ovf), 64'(0));
        chk("t6_loaded_in_reset", 64'(loaded), 64'(0));
        rst = 0; hold1 = 0;
        repeat (3) @(negedge clk);
        chk("t6_no_spurious_req", 64'(p1_req), 64'(1));
        chk("t6_busy_after", 64'(busy), 64'(0));
        chk("t6_loaded_during_dl", 64'(loaded), 64'(0));
        downl = 0;
        @(negedge clk);
        chk("t6_rom_loaded", 64'(loaded), 64'(1));
        repeat (4) @(negedge clk);
        chk("t6_rom_loaded_sticky", 64'(loaded), 64'(1));
        chk("t6_port_we_idle", 64'(port_we), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
